fifo_1r1w_small: RTL and testbench
==================================

// Module: fifo_1r1w_small
// PURPOSE
//  Small one-read/one-write FIFO buffering fixed-width words between a ready/valid producer
//  and a valid/yumi consumer. Used as the outstanding-command queue in front of host I/O
//  responders (e.g. 32 deep, one mem-message wide); the consumer's yumi dequeues the head.
// PARAMETERS
//  width_p  8   data word width in bits (>=1)
//  els_p    32  number of entries (>=2; need not be a power of two)
// PORTS
//  clk_i      in   1        clock; all state updates on rising edge
//  reset_n_i  in   1        asynchronous active-low reset
//  data_i     in   width_p  write data
//  v_i        in   1        write valid
//  ready_o    out  1        FIFO can accept a word this cycle (not full)
//  data_o     out  width_p  head-of-queue word
//  v_o        out  1        FIFO holds at least one word (not empty)
//  yumi_i     in   1        consumer takes head this cycle; legal only while v_o=1
// BEHAVIOUR
//  - Reset (reset_n_i=0, async assert, sync-safe deassert): rd/wr pointers=0, empty, not full;
//    ready_o=1, v_o=0 immediately. Storage array is not reset; data_o is don't-care while v_o=0.
//  - Enqueue when v_i & ready_o at posedge: data_i written at wr_ptr; wr_ptr advances.
//    v_i while ready_o=0: word dropped, no state change.
//  - Dequeue when yumi_i at posedge: rd_ptr advances. yumi_i while v_o=0: ignored.
//  - ready_o = ~full, v_o = ~empty; both are pure register outputs (no comb path from v_i/yumi_i).
//  - data_o = mem[rd_ptr], combinational read of storage; no bypass: a word enqueued into an
//    empty FIFO appears on data_o/v_o one cycle later (1-cycle latency).
//  - Pointers wrap from els_p-1 to 0; width = clog2(els_p) (min 1).
//  - Full/empty tracking: flag updated per cycle:
//      enq only: empty<=0; full<=1 if next wr_ptr == rd_ptr
//      deq only: full<=0; empty<=1 if next rd_ptr == wr_ptr
//      enq & deq same cycle (only possible when not full and not empty): occupancy unchanged,
//      both pointers advance, flags unchanged.
//  - Strict FIFO order; capacity exactly els_p words; no word lost or duplicated.
//  - Reset asserted mid-operation: all contents discarded, outputs return to reset values
//    asynchronously.
// CONFIGURATION
//  FIFO_1R1W_SMALL_CHECK_EN (define to enable):
//   defined: nonsynth checks at posedge when reset_n_i=1: v_i&~ready_o -> $error "enq when full";
//     yumi_i&~v_o -> $error "deq when empty"; also $error at elaboration if els_p<2.
//   undefined: no checks; illegal requests silently ignored exactly as described above.
//  Functional behaviour is identical in both builds.
// TESTING  (width_p=8, els_p=4 unless noted)
//  1 Reset: reset_n_i=0 mid-clock -> ready_o=1, v_o=0 without waiting for an edge.
//  2 Single word: enq 8'hA5 -> next cycle v_o=1, data_o=8'hA5; yumi_i -> next cycle v_o=0.
//  3 Fill: enq 01,02,03,04 -> ready_o=0 after 4th; extra enq 05 dropped; dequeue yields 01..04
//    then v_o=0, ready_o back to 1 after first dequeue.
//  4 Simultaneous: with 2 words held, enq+yumi same cycle for 10 cycles -> occupancy stays 2,
//    ordered output, pointers wrap correctly.
//  5 Non-power-of-two els_p=3: 7 enq/deq interleavings incl. wrap -> order preserved, full at 3.
//  6 Mid-op reset with 3 words held -> v_o=0, ready_o=1; subsequent enq 8'h3C read back alone.

Source files
------------

// File: rtl/fifo_1r1w_small.sv
// Small one-read/one-write FIFO: ready/valid producer side, valid/yumi consumer side.
// Optional simulation-only protocol checks are enabled by defining FIFO_1R1W_SMALL_CHECK_EN.
module fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 2) ? $clog2(els_p) : 1;
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);

  // Handshake: a word is written when v_i & ready_o at posedge; the head is
  // removed when yumi_i (legal only while v_o) at posedge. Other requests are ignored.
  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] rd_ptr_r, wr_ptr_r;
  logic [ptr_w_lp-1:0] rd_ptr_nxt, wr_ptr_nxt;
  logic                full_r, empty_r;
  logic                enq, deq;

  assign enq = v_i & ~full_r;
  assign deq = yumi_i & ~empty_r;

  assign rd_ptr_nxt = (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + 1'b1;
  assign wr_ptr_nxt = (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + 1'b1;

  assign ready_o = ~full_r;
  assign v_o     = ~empty_r;
  assign data_o  = mem[rd_ptr_r];

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr_r] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (enq) wr_ptr_r <= wr_ptr_nxt;
      if (deq) rd_ptr_r <= rd_ptr_nxt;
      // Simultaneous enq/deq keeps occupancy, so the flags only move on one-sided traffic.
      if (enq && !deq) begin
        empty_r <= 1'b0;
        full_r  <= (wr_ptr_nxt == rd_ptr_r);
      end else if (deq && !enq) begin
        full_r  <= 1'b0;
        empty_r <= (rd_ptr_nxt == wr_ptr_r);
      end
    end
  end

`ifdef FIFO_1R1W_SMALL_CHECK_EN
  if (els_p < 2) begin : g_bad_els
    $error("fifo_1r1w_small: els_p must be >= 2");
  end

  always @(posedge clk_i) begin
    if (reset_n_i) begin
      if (v_i && !ready_o) $error("enq when full");
      if (yumi_i && !v_o)  $error("deq when empty");
    end
  end
`else
  // Illegal requests are filtered by the enq/deq qualification above.
`endif

endmodule

// File: tb/tb_fifo_1r1w_small.sv
// Directed bench for fifo_1r1w_small: a 4-deep instance for the main scenarios and
// a 3-deep instance for non-power-of-two wrap behaviour.
module tb_fifo_1r1w_small;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 4-deep instance
  logic       rst_a_n = 1'b1;
  logic [7:0] data_a_i = '0, data_a_o;
  logic       v_a_i = 1'b0, ready_a_o, v_a_o, yumi_a_i = 1'b0;

  // 3-deep instance
  logic       rst_b_n = 1'b1;
  logic [7:0] data_b_i = '0, data_b_o;
  logic       v_b_i = 1'b0, ready_b_o, v_b_o, yumi_b_i = 1'b0;

  fifo_1r1w_small #(.width_p(8), .els_p(4)) dut_a (
    .clk_i(clk), .reset_n_i(rst_a_n), .data_i(data_a_i), .v_i(v_a_i),
    .ready_o(ready_a_o), .data_o(data_a_o), .v_o(v_a_o), .yumi_i(yumi_a_i)
  );

  fifo_1r1w_small #(.width_p(8), .els_p(3)) dut_b (
    .clk_i(clk), .reset_n_i(rst_b_n), .data_i(data_b_i), .v_i(v_b_i),
    .ready_o(ready_b_o), .data_o(data_b_o), .v_o(v_b_o), .yumi_i(yumi_b_i)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic sb_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle on instance A; inputs are applied 1ns after the edge and released after the next.
  task automatic step_a(input logic v, input logic [7:0] d, input logic y);
    v_a_i = v; data_a_i = d; yumi_a_i = y;
    @(posedge clk); #1;
    v_a_i = 1'b0; data_a_i = '0; yumi_a_i = 1'b0;
  endtask

  task automatic step_b(input logic v, input logic [7:0] d, input logic y);
    v_b_i = v; data_b_i = d; yumi_b_i = y;
    @(posedge clk); #1;
    v_b_i = 1'b0; data_b_i = '0; yumi_b_i = 1'b0;
  endtask

  // {v, yumi, data} per cycle for the 3-deep instance
  logic [9:0] ops_b [15] = '{
    {2'b10, 8'h41}, {2'b10, 8'h42}, {2'b10, 8'h43}, {2'b10, 8'h44},
    {2'b01, 8'h00}, {2'b10, 8'h45}, {2'b11, 8'h46}, {2'b01, 8'h00},
    {2'b11, 8'h47}, {2'b11, 8'h48}, {2'b01, 8'h00}, {2'b01, 8'h00},
    {2'b01, 8'h00}, {2'b10, 8'h49}, {2'b01, 8'h00}
  };

  initial begin
    logic [9:0] op;
    logic       do_enq, do_deq;

    // Reset takes effect asynchronously, before any clock edge.
    #1 rst_a_n = 1'b0; rst_b_n = 1'b0;
    #1;
    sb_check("reset_ready", {31'd0, ready_a_o}, 32'd1);
    sb_check("reset_v",     {31'd0, v_a_o},     32'd0);
    sb_check("reset_b_v",   {31'd0, v_b_o},     32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(posedge clk); #1;

    // Single word with one-cycle latency
    v_a_i = 1'b1; data_a_i = 8'hA5;
    #1 sb_check("no_bypass_v", {31'd0, v_a_o}, 32'd0);
    @(posedge clk); #1; v_a_i = 1'b0;
    sb_check("single_v",    {31'd0, v_a_o}, 32'd1);
    sb_check("single_data", {24'd0, data_a_o}, 32'hA5);
    step_a(1'b0, 8'h00, 1'b1);
    sb_check("single_empty", {31'd0, v_a_o}, 32'd0);

    // Fill to capacity, extra word dropped
    step_a(1'b1, 8'h01, 1'b0);
    step_a(1'b1, 8'h02, 1'b0);
    step_a(1'b1, 8'h03, 1'b0);
    sb_check("fill3_ready", {31'd0, ready_a_o}, 32'd1);
    step_a(1'b1, 8'h04, 1'b0);
    sb_check("fill4_ready", {31'd0, ready_a_o}, 32'd0);
    sb_check("fill4_head",  {24'd0, data_a_o},  32'h01);
    step_a(1'b1, 8'h05, 1'b0);
    sb_check("drop_ready", {31'd0, ready_a_o}, 32'd0);
    sb_check("drop_head",  {24'd0, data_a_o},  32'h01);
    step_a(1'b0, 8'h00, 1'b1);
    sb_check("pop1_ready", {31'd0, ready_a_o}, 32'd1);
    sb_check("pop1_head",  {24'd0, data_a_o},  32'h02);
    step_a(1'b0, 8'h00, 1'b1);
    sb_check("pop2_head",  {24'd0, data_a_o},  32'h03);
    step_a(1'b0, 8'h00, 1'b1);
    sb_check("pop3_head",  {24'd0, data_a_o},  32'h04);
    step_a(1'b0, 8'h00, 1'b1);
    sb_check("drain_v",    {31'd0, v_a_o},     32'd0);

    // Yumi while empty is ignored
    step_a(1'b0, 8'h00, 1'b1);
    sb_check("deq_empty_v",     {31'd0, v_a_o},     32'd0);
    sb_check("deq_empty_ready", {31'd0, ready_a_o}, 32'd1);

    // Simultaneous enq/deq with two words held
    step_a(1'b1, 8'h10, 1'b0);
    step_a(1'b1, 8'h11, 1'b0);
    sb_check("sim_pre_head", {24'd0, data_a_o}, 32'h10);
    exp_q = '{8'h10, 8'h11};
    for (int i = 0; i < 10; i++) begin
      step_a(1'b1, 8'h20 + 8'(i), 1'b1);
      exp_q.push_back(8'h20 + 8'(i));
      void'(exp_q.pop_front());
      sb_check($sformatf("sim%0d_head", i),  {24'd0, data_a_o},  {24'd0, exp_q[0]});
      sb_check($sformatf("sim%0d_v", i),     {31'd0, v_a_o},     32'd1);
      sb_check($sformatf("sim%0d_ready", i), {31'd0, ready_a_o}, 32'd1);
    end
    step_a(1'b0, 8'h00, 1'b1);
    sb_check("sim_tail0", {24'd0, data_a_o}, 32'h29);
    step_a(1'b0, 8'h00, 1'b1);
    sb_check("sim_tail_v", {31'd0, v_a_o}, 32'd0);

    // Mid-operation reset with three words held
    step_a(1'b1, 8'h31, 1'b0);
    step_a(1'b1, 8'h32, 1'b0);
    step_a(1'b1, 8'h33, 1'b0);
    sb_check("mid_pre_v", {31'd0, v_a_o}, 32'd1);
    #2 rst_a_n = 1'b0;
    #1;
    sb_check("mid_rst_v",     {31'd0, v_a_o},     32'd0);
    sb_check("mid_rst_ready", {31'd0, ready_a_o}, 32'd1);
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    step_a(1'b1, 8'h3C, 1'b0);
    sb_check("post_rst_head", {24'd0, data_a_o}, 32'h3C);
    step_a(1'b0, 8'h00, 1'b1);
    sb_check("post_rst_empty", {31'd0, v_a_o}, 32'd0);

    // Three-deep instance: queue model decides what each cycle accepts
    exp_q.delete();
    for (int i = 0; i < 15; i++) begin
      op = ops_b[i];
      do_enq = op[9] && (exp_q.size() < 3);
      do_deq = op[8] && (exp_q.size() > 0);
      step_b(op[9], op[7:0], op[8]);
      if (do_deq) void'(exp_q.pop_front());
      if (do_enq) exp_q.push_back(op[7:0]);
      sb_check($sformatf("b%0d_v", i),     {31'd0, v_b_o},     {31'd0, exp_q.size() > 0});
      sb_check($sformatf("b%0d_ready", i), {31'd0, ready_b_o}, {31'd0, exp_q.size() < 3});
      if (exp_q.size() > 0)
        sb_check($sformatf("b%0d_head", i), {24'd0, data_b_o}, {24'd0, exp_q[0]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
